tick_gen_multi: RTL

Parametrised multi-channel tick generator. Produces NUM_CH independent one-cycle strobes and matching 50%-duty square waves from the single system clock. Replaces the fixed four-counter divider used for the score, fast-score, display-mux and blink timebases. Adds per-channel enables, a runtime-programmable divisor, and a global phase-sync restart.

---
 rtl/tick_gen_multi.sv | 91 +++++++++
 1 files changed

// File: rtl/tick_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_multi
// Purpose  : NUM_CH independent one-cycle tick strobes and 50%-duty square
//            waves, each with enable, shadowed runtime divisor and sync restart.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen_multi #(
  parameter int                        NUM_CH   = 4,
  parameter int                        CNT_W    = 26,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {26'd50000000, 26'd200000,
                                                   26'd100000,   26'd5000000},
  parameter int                        CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  // One extra bit so NUM_CH itself is representable when cfg_ch is full width.
  localparam logic [CH_W:0] c_NUM_CH = (CH_W+1)'(NUM_CH);

  logic w_cfg_ok;
  assign w_cfg_ok = cfg_we && ({1'b0, cfg_ch} < c_NUM_CH);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [CNT_W-1:0] c_INIT = DIV_INIT[i*CNT_W +: CNT_W];
      localparam logic [CH_W-1:0]  c_IDX  = CH_W'(i);

      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_div_act;
      logic [CNT_W-1:0] r_div_sh;
      logic             r_tick;
      logic             r_sq;
      logic             w_wr;
      logic             w_wrap;

      assign w_wr   = w_cfg_ok && (cfg_ch == c_IDX);
      assign w_wrap = (r_cnt == r_div_act);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_div_sh <= c_INIT;
        end else if (w_wr) begin
          r_div_sh <= cfg_div;
        end
      end

      // Loads of r_div_act see the pre-write shadow, so a write on a wrap
      // cycle only takes effect from the following wrap.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt     <= '0;
          r_tick    <= 1'b0;
          r_sq      <= 1'b0;
          r_div_act <= c_INIT;
        end else if (sync) begin
          r_cnt     <= '0;
          r_tick    <= 1'b0;
          r_sq      <= 1'b0;
          r_div_act <= r_div_sh;
        end else if (en[i]) begin
          if (w_wrap) begin
            r_cnt     <= '0;
            r_tick    <= 1'b1;
            r_sq      <= ~r_sq;
            r_div_act <= r_div_sh;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
          end
        end else begin
          r_tick    <= 1'b0;
          r_div_act <= r_div_sh;
        end
      end

      assign tick[i] = r_tick;
      assign sq[i]   = r_sq;
    end
  endgenerate

endmodule
`default_nettype wire
